noc_packetizer_sc: RTL

Single-clock, parametrised AXI-Stream-to-NoC packetizer. It converts AXIS messages of any beat width into header/body/tail flits, splits long messages into bounded-length packets, and buffers outgoing flits in an internal synchronous FIFO. It sits in the network interface between a NoC-clocked AXIS producer and the router injection port, and needs no clock-domain crossing.

---
 rtl/noc_packetizer_sc_pkg.sv | 41 ++++
 rtl/noc_packetizer_sc_if.sv | 41 ++++
 rtl/noc_packetizer_sc_fifo.sv | 63 ++++++
 rtl/noc_packetizer_sc.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/noc_packetizer_sc_pkg.sv
// Shared encodings and header-layout helpers for the AXIS-to-NoC packetizer.
// Header fields are packed MSB-down: dest, src, tid, cont, then zero fill.
package noc_packetizer_pkg;

    typedef enum logic [1:0] {
        FLIT_HEADER = 2'b00,
        FLIT_BODY   = 2'b01,
        FLIT_TAIL   = 2'b10
    } flit_type_e;

    typedef enum logic {
        ST_IDLE,
        ST_DATA
    } pk_state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    function automatic int hdr_dest_lsb(input int noc_w, input int dest_w);
        return noc_w - dest_w;
    endfunction

    function automatic int hdr_src_lsb(input int noc_w, input int dest_w);
        return noc_w - 2 * dest_w;
    endfunction

    function automatic int hdr_tid_lsb(input int noc_w, input int dest_w, input int tid_w);
        return noc_w - 2 * dest_w - tid_w;
    endfunction

    function automatic int hdr_cont_bit(input int noc_w, input int dest_w, input int tid_w);
        return noc_w - 2 * dest_w - tid_w - 1;
    endfunction

endpackage

// File: rtl/noc_packetizer_sc_if.sv
// AXIS ingress and NoC injection signals of the packetizer as one bundle.
// slave is the packetizer's view, master is the surrounding producer/router view.
interface noc_packetizer_sc_if #(
    parameter int AxisDataWidth            = 8,
    parameter int NocDataWidth             = 64,
    parameter int TIdWidth                 = 8,
    parameter int TDestWidth               = 11,
    parameter int NocVirtualChannelIdWidth = 3,
    parameter int NocBroadcastWidth        = 1,
    parameter int TailBytesWidth           = noc_packetizer_pkg::clog2(NocDataWidth / 8) + 1
);
    logic [AxisDataWidth-1:0]            s_axis_tdata;
    logic                                s_axis_tvalid;
    logic                                s_axis_tready;
    logic                                s_axis_tlast;
    logic [TIdWidth-1:0]                 s_axis_tid;
    logic [TDestWidth-1:0]               s_axis_tdest;
    logic [NocDataWidth-1:0]             network_flit_o;
    logic [1:0]                          network_flit_type_o;
    logic [NocVirtualChannelIdWidth-1:0] network_vc_o;
    logic [NocBroadcastWidth-1:0]        network_broadcast_o;
    logic [TailBytesWidth-1:0]           network_tail_bytes_o;
    logic                                network_valid_o;
    logic                                network_ready_i;

    modport slave (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, s_axis_tid, s_axis_tdest,
        input  network_ready_i,
        output s_axis_tready,
        output network_flit_o, network_flit_type_o, network_vc_o, network_broadcast_o,
        output network_tail_bytes_o, network_valid_o
    );

    modport master (
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast, s_axis_tid, s_axis_tdest,
        output network_ready_i,
        input  s_axis_tready,
        input  network_flit_o, network_flit_type_o, network_vc_o, network_broadcast_o,
        input  network_tail_bytes_o, network_valid_o
    );
endinterface

// File: rtl/noc_packetizer_sc_fifo.sv
// Synchronous FIFO with a registered head; dout reads 0 while empty.
// Push into a full FIFO and pop from an empty one are ignored.
module noc_flit_fifo
    import noc_packetizer_pkg::*;
#(
    parameter int Width = 8,
    parameter int Depth = 4
) (
    input  logic                   clk_noc,
    input  logic                   rst_noc,
    input  logic                   push,
    input  logic [Width-1:0]       din,
    input  logic                   pop,
    output logic [Width-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [clog2(Depth):0]  count
);
    localparam int PtrW = clog2(Depth);
    localparam int CntW = PtrW + 1;

    logic [Width-1:0] mem [Depth];
    logic [PtrW-1:0]  wr_ptr, rd_ptr, rd_nxt;
    logic [CntW-1:0]  cnt_q;
    logic [Width-1:0] head_q;
    logic             push_ok, pop_ok;

    assign full    = (cnt_q == CntW'(Depth));
    assign empty   = (cnt_q == '0);
    assign count   = cnt_q;
    assign dout    = head_q;
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rd_nxt  = rd_ptr + 1'b1;

    always_ff @(posedge clk_noc) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk_noc) begin
        if (rst_noc) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
            head_q <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_nxt;
            case ({push_ok, pop_ok})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
            // Head tracks the next front entry so the output never reads the array directly.
            if (pop_ok) begin
                if (cnt_q == CntW'(1)) head_q <= push_ok ? din : '0;
                else                   head_q <= mem[rd_nxt];
            end else if (empty && push_ok) begin
                head_q <= din;
            end
        end
    end
endmodule

// File: rtl/noc_packetizer_sc.sv
// AXIS-to-NoC packetizer: HEADER/BODY/TAIL flits, optional packet splitting, output FIFO.
// Flit visible the cycle after its push when the FIFO is empty; input stalls while the FIFO is full.
module noc_packetizer_sc
    import noc_packetizer_pkg::*;
#(
    parameter int AxisDataWidth            = 8,
    parameter int NocDataWidth             = 64,
    parameter int TIdWidth                 = 8,
    parameter int TDestWidth               = 11,
    parameter int NumVn                    = 3,
    parameter int NocVirtualChannelIdWidth = 3,
    parameter int NocBroadcastWidth        = 1,
    parameter int SourceId                 = 1,
    parameter int MaxFlits                 = 0,
    parameter int OutFifoDepth             = 4
) (
    input  logic             clk_noc,
    input  logic             rst_noc,
    noc_packetizer_sc_if.slave bus
);
    localparam int Beats    = NocDataWidth / AxisDataWidth;
    localparam int BcW      = (Beats > 1) ? clog2(Beats) : 1;
    localparam int NocBytes = NocDataWidth / 8;
    localparam int TbW      = clog2(NocBytes) + 1;
    localparam int VcW      = NocVirtualChannelIdWidth;
    localparam int EntW     = NocDataWidth + 2 + TbW + VcW;
    localparam int CntW     = clog2(OutFifoDepth) + 1;
    localparam int DestLsb  = hdr_dest_lsb(NocDataWidth, TDestWidth);
    localparam int SrcLsb   = hdr_src_lsb(NocDataWidth, TDestWidth);
    localparam int TidLsb   = hdr_tid_lsb(NocDataWidth, TDestWidth, TIdWidth);
    localparam int ContBit  = hdr_cont_bit(NocDataWidth, TDestWidth, TIdWidth);

    pk_state_e               state_q;
    logic [NocDataWidth-1:0] asm_q;
    logic [BcW-1:0]          beat_q;
    logic [31:0]             flit_cnt_q;
    logic                    cont_q;
    logic [VcW-1:0]          vc_q;

    logic                    fifo_full, fifo_empty, pop;
    logic [CntW-1:0]         fifo_count;
    logic [EntW-1:0]         fifo_dout;

    logic                    beat_acc, flit_full, max_hit, push;
    logic [NocDataWidth-1:0] hdr, flit_nxt, push_flit;
    flit_type_e              push_type;
    logic [TbW-1:0]          push_tb;
    logic [VcW-1:0]          push_vc;

    always_comb begin
        hdr = '0;
        hdr[DestLsb +: TDestWidth] = bus.s_axis_tdest;
        hdr[SrcLsb +: TDestWidth]  = TDestWidth'(SourceId);
        hdr[TidLsb +: TIdWidth]    = bus.s_axis_tid;
        hdr[ContBit]               = cont_q;

        beat_acc  = (state_q == ST_DATA) && bus.s_axis_tvalid && !fifo_full;
        // Unfilled lanes of asm_q are zero, so OR-ing the shifted beat in is enough.
        flit_nxt  = asm_q | (NocDataWidth'(bus.s_axis_tdata) << (32'(beat_q) * AxisDataWidth));
        flit_full = (32'(beat_q) == Beats - 1);
        max_hit   = (MaxFlits != 0) && (flit_cnt_q + 32'd1 == 32'(MaxFlits));

        push      = 1'b0;
        push_type = FLIT_HEADER;
        push_flit = '0;
        push_tb   = '0;
        push_vc   = vc_q;
        if (state_q == ST_IDLE) begin
            push      = bus.s_axis_tvalid && !fifo_full;
            push_flit = hdr;
            push_vc   = VcW'(32'(bus.s_axis_tid) % NumVn);
        end else if (beat_acc) begin
            push_flit = flit_nxt;
            if (bus.s_axis_tlast) begin
                push      = 1'b1;
                push_type = FLIT_TAIL;
                push_tb   = TbW'((32'(beat_q) + 1) * (AxisDataWidth / 8));
            end else if (flit_full && max_hit) begin
                push      = 1'b1;
                push_type = FLIT_TAIL;
                push_tb   = TbW'(NocBytes);
            end else if (flit_full) begin
                push      = 1'b1;
                push_type = FLIT_BODY;
            end
        end
    end

    always_ff @(posedge clk_noc) begin
        if (rst_noc) begin
            state_q    <= ST_IDLE;
            asm_q      <= '0;
            beat_q     <= '0;
            flit_cnt_q <= '0;
            cont_q     <= 1'b0;
            vc_q       <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (push) begin
                        vc_q    <= push_vc;
                        state_q <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (beat_acc) begin
                        if (bus.s_axis_tlast || flit_full) begin
                            asm_q  <= '0;
                            beat_q <= '0;
                            if (push_type == FLIT_TAIL) begin
                                // A length-limited tail leaves the message open for a cont packet.
                                state_q    <= ST_IDLE;
                                flit_cnt_q <= '0;
                                cont_q     <= !bus.s_axis_tlast;
                            end else begin
                                flit_cnt_q <= flit_cnt_q + 32'd1;
                            end
                        end else begin
                            asm_q  <= flit_nxt;
                            beat_q <= beat_q + 1'b1;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    noc_flit_fifo #(
        .Width (EntW),
        .Depth (OutFifoDepth)
    ) u_fifo (
        .clk_noc (clk_noc),
        .rst_noc (rst_noc),
        .push    (push),
        .din     ({push_flit, push_type, push_tb, push_vc}),
        .pop     (pop),
        .dout    (fifo_dout),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign pop                      = !fifo_empty && bus.network_ready_i;
    assign bus.s_axis_tready        = (state_q == ST_DATA) && !fifo_full;
    assign bus.network_valid_o      = !fifo_empty;
    assign bus.network_flit_o       = fifo_dout[EntW-1 -: NocDataWidth];
    assign bus.network_flit_type_o  = fifo_dout[TbW+VcW +: 2];
    assign bus.network_tail_bytes_o = fifo_dout[VcW +: TbW];
    assign bus.network_vc_o         = fifo_dout[0 +: VcW];
    assign bus.network_broadcast_o  = '0;

    a_count_bound: assert property (@(posedge clk_noc) disable iff (rst_noc)
        fifo_count <= CntW'(OutFifoDepth));
endmodule
